game_timer: RTL

- Parametrised countdown timer for game rounds; successor to the fixed 5-bit free-running down counter.
- Adds:
  - configurable width and start value
  - pause/hold
  - runtime load
  - wrap-or-expire mode selection
  - explicit state machine with expiry flag and one-cycle done pulse
- Runs in the slow game clock domain; feeds the score/compare logic and display driver.

---
 rtl/game_timer_pkg.sv | 22 ++
 rtl/game_timer_lap.sv | 28 ++
 rtl/game_timer.sv | 106 ++++++++++
 3 files changed

// File: rtl/game_timer_pkg.sv
// Shared types and state encodings for the game round countdown timer.
// The display and score blocks decode state_o with the STATE_* constants.
package game_timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      HOLD    = 2'd2,
      EXPIRED = 2'd3
   } timer_state_e;

   localparam logic [1:0] STATE_IDLE    = 2'd0;
   localparam logic [1:0] STATE_RUN     = 2'd1;
   localparam logic [1:0] STATE_HOLD    = 2'd2;
   localparam logic [1:0] STATE_EXPIRED = 2'd3;

   // States in which the count is live (running or paused).
   function automatic logic is_active(timer_state_e s);
      return (s == RUN) || (s == HOLD);
   endfunction

endpackage

// File: rtl/game_timer_lap.sv
// Lap capture register: snapshots the live count on lap_i while the timer is active.
// Only instantiated when GAME_TIMER_LAP_EN is defined.
module game_timer_lap #(
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk_4_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             lap_i,
   input  logic             active,
   input  logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] lap_count_o,
   output logic             lap_valid_o
);

   always_ff @(posedge clk_4_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lap_count_o <= '0;
         lap_valid_o <= 1'b0;
      end else if (!en_i) begin
         lap_valid_o <= 1'b0;
      end else if (lap_i && active) begin
         lap_count_o <= count;
         lap_valid_o <= 1'b1;
      end
   end

endmodule

// File: rtl/game_timer.sv
// Parametrised game-round countdown timer with pause, runtime load and wrap/expire modes.
// Optional lap capture is enabled by defining GAME_TIMER_LAP_EN.
module game_timer
   import game_timer_pkg::*;
#(
   parameter int unsigned WIDTH     = 5,
   parameter int unsigned START_VAL = (1 << WIDTH) - 1,
   parameter bit          WRAP      = 1'b0
) (
   input  logic             clk_4_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             hold_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
`ifdef GAME_TIMER_LAP_EN
   input  logic             lap_i,
   output logic [WIDTH-1:0] lap_count_o,
   output logic             lap_valid_o,
`endif
   output logic [WIDTH-1:0] count_o,
   output logic [1:0]       state_o,
   output logic             expired_o,
   output logic             done_o
);

   localparam logic [WIDTH-1:0] START = WIDTH'(START_VAL);

   timer_state_e     state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             done_q, done_d;

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_4_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         count_q <= START;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   // NOTE: defaults first so every path assigns every signal and no latch is inferred.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      done_d  = 1'b0;
      if (!en_i) begin
         state_d = IDLE;
         count_d = START;
      end else if (load_i) begin
         count_d = load_val_i;
         state_d = hold_i ? HOLD : RUN;
         if (load_val_i == '0) begin
            done_d = ~done_q;
            if (!WRAP) state_d = EXPIRED;
         end
      end else begin
         unique case (state_q)
            IDLE:    state_d = hold_i ? HOLD : RUN;
            EXPIRED: state_d = EXPIRED;
            default: begin
               // Count 0 in RUN/HOLD only exists in wrap mode: reload on the next edge.
               if (WRAP && count_q == '0) begin
                  count_d = START;
                  state_d = hold_i ? HOLD : RUN;
               end else if (hold_i) begin
                  state_d = HOLD;
               end else if (state_q == HOLD) begin
                  state_d = RUN;
               end else begin
                  count_d = count_q - WIDTH'(1);
                  if (count_q == WIDTH'(1)) begin
                     done_d = ~done_q;
                     if (!WRAP) state_d = EXPIRED;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      state_o   = state_q;
      expired_o = (state_q == EXPIRED);
      count_o   = count_q;
      done_o    = done_q;
   end

`ifdef GAME_TIMER_LAP_EN
   game_timer_lap #(.WIDTH(WIDTH)) u_lap (
      .clk_4_i     (clk_4_i),
      .rst_ni      (rst_ni),
      .en_i        (en_i),
      .lap_i       (lap_i),
      .active      (is_active(state_q)),
      .count       (count_q),
      .lap_count_o (lap_count_o),
      .lap_valid_o (lap_valid_o)
   );
`endif

endmodule
